// File: rtl/kd_tree_node_loader.sv
// KD-tree internal-node loader: streams config words into the node array in
// breadth-first order, then reads every node back and checks its split dimension.
module kd_tree_node_loader #(
    parameter int unsigned NUM_NODES     = 31,
    parameter int unsigned STORAGE_WIDTH = 22,
    parameter int unsigned ADDR_WIDTH    = 5,
    parameter int unsigned NUM_DIMS      = 5
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [STORAGE_WIDTH-1:0]           in_data,
    output logic [NUM_NODES-1:0]               wen,
    output logic [STORAGE_WIDTH-1:0]           wdata,
    input  logic [NUM_NODES*STORAGE_WIDTH-1:0] rdata_flat,
    output logic                               busy,
    output logic                               done,
    output logic                               error,
    output logic [ADDR_WIDTH-1:0]              err_node
);

    localparam int unsigned IDX_W   = 3;
    localparam int unsigned MED_LSB = 11;
    localparam int unsigned PAD_W   = MED_LSB - IDX_W;
    localparam logic [ADDR_WIDTH-1:0] LAST_NODE = ADDR_WIDTH'(NUM_NODES - 1);
    localparam logic [IDX_W-1:0]      DIM_LIMIT = IDX_W'(NUM_DIMS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_VERIFY,
        S_DONE
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   wr_cnt_q;
    logic [ADDR_WIDTH-1:0]   rd_cnt_q;
    logic                    in_ready_q;
    logic [NUM_NODES-1:0]    wen_q;
    logic [STORAGE_WIDTH-1:0] wdata_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    error_q;
    logic [ADDR_WIDTH-1:0]   err_node_q;

    logic [NUM_NODES-1:0][IDX_W-1:0] rd_idx_c;
    logic                            rd_bad_c;
    logic                            hs_c;
    logic                            unused_c;

    // Only the idx field of each readback is inspected.
    for (genvar g = 0; g < NUM_NODES; g++) begin : g_rd_idx
        assign rd_idx_c[g] = rdata_flat[g*STORAGE_WIDTH +: IDX_W];
    end

    assign rd_bad_c = (rd_idx_c[rd_cnt_q] >= DIM_LIMIT);
    assign hs_c     = in_valid & in_ready_q;
    assign unused_c = ^{in_data[MED_LSB-1:IDX_W], rdata_flat};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            in_ready_q <= 1'b0;
            wen_q      <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_node_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q    <= S_LOAD;
                        wr_cnt_q   <= '0;
                        error_q    <= 1'b0;
                        err_node_q <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    wen_q <= '0;
                    if (hs_c) begin
                        // Don't-care bits are zeroed; idx is written unchecked.
                        wen_q    <= NUM_NODES'(1) << wr_cnt_q;
                        wdata_q  <= {in_data[STORAGE_WIDTH-1:MED_LSB], PAD_W'(0),
                                     in_data[IDX_W-1:0]};
                        wr_cnt_q <= wr_cnt_q + ADDR_WIDTH'(1);
                        if (wr_cnt_q == LAST_NODE) begin
                            state_q    <= S_SETTLE;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                S_SETTLE: begin
                    wen_q    <= '0;
                    rd_cnt_q <= '0;
                    state_q  <= S_VERIFY;
                end
                S_VERIFY: begin
                    if (rd_bad_c) begin
                        err_node_q <= rd_cnt_q;
                        error_q    <= 1'b1;
                        state_q    <= S_DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end else if (rd_cnt_q == LAST_NODE) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    wen_q      <= '0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign wen      = wen_q;
    assign wdata    = wdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign err_node = err_node_q;

endmodule
